// File: rtl/mmult_sched_pkg.sv
// rtl/mmult_sched_pkg.sv - shared state encoding and counter width helper for mmult_sched
// Contents: state_e (sequencer states), idx_bits() (index width, minimum 1 bit).
package mmult_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_e;

    // Width of an index counting 0..n-1; a single entry still needs one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmult_sched_watchdog.sv
// rtl/mmult_sched_watchdog.sv - cycle watchdog for the multiplier WAIT phase
// Ports: clk, aresetn (async, active low), clear_i (restart count),
//        count_en_i (count this cycle), expire_o (limit reached this cycle).
module mmult_sched_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic aresetn,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expire_o
);

    localparam int TW = $clog2(LIMIT + 1);
    localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (count_en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    // The LIMIT-th counted cycle is the expiring one.
    assign expire_o = count_en_i && (cnt_q == LAST);

endmodule

// File: rtl/mmult_sched.sv
// rtl/mmult_sched.sv - per-column sequencer for the block-column matrix multiplier
// Host side: sched_start in; sched_busy, sched_done, sched_error out.
// Multiplier side: mm_start, mm_col out; mm_done, mm_result_valid, mm_result in.
// Result RAM: res_write_en, res_write_address, res_write_data out.
// Optional macro MMULT_SCHED_TIMEOUT_EN adds a WAIT-phase watchdog (TIMEOUT_CYCLES).
module mmult_sched
    import mmult_sched_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int M              = 8,
    parameter int P              = 2,
    parameter int RES_DEPTH_BITS = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      sched_start,
    output logic                      sched_busy,
    output logic                      sched_done,
    output logic                      sched_error,
    output logic                      mm_start,
    output logic [idx_bits(P)-1:0]    mm_col,
    input  logic                      mm_done,
    input  logic                      mm_result_valid,
    input  logic [WIDTH-1:0]          mm_result,
    output logic                      res_write_en,
    output logic [RES_DEPTH_BITS-1:0] res_write_address,
    output logic [WIDTH-1:0]          res_write_data
);

    localparam int CW = idx_bits(P);
    localparam int RW = $clog2(M) + 1;
    localparam int AW = RES_DEPTH_BITS;
    localparam logic [RW-1:0] ROWS     = RW'(M);
    localparam logic [CW-1:0] LAST_COL = CW'(P - 1);
    localparam logic [AW-1:0] M_A      = AW'(M);

    state_e         state_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic [RW-1:0]  row_d;
    logic           busy_q, done_q, err_q, mm_start_q;
    logic           wr_en_q;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q;
    logic           in_wait, accept, wd_expire;

    always_comb begin
        in_wait   = (state_q == ST_WAIT);
        // Only the first M valids of a column are stored; later ones overflow.
        accept    = in_wait && mm_result_valid && (row_q < ROWS);
        row_d     = accept ? row_q + RW'(1) : row_q;
        wr_addr_d = AW'(col_q) * M_A + AW'(row_q);
    end

`ifdef MMULT_SCHED_TIMEOUT_EN
    mmult_sched_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .aresetn    (aresetn),
        .clear_i    ((state_q == ST_LAUNCH) || (in_wait && mm_result_valid)),
        .count_en_i (in_wait),
        .expire_o   (wd_expire)
    );
`else
    // No watchdog: constant 0 (a negative limit is not a legal setting).
    assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mm_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            mm_start_q <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sched_start) begin
                        state_q    <= ST_LAUNCH;
                        col_q      <= '0;
                        row_q      <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        mm_start_q <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_addr_d;
                        wr_data_q <= mm_result;
                    end
                    if (mm_result_valid && !accept) begin
                        err_q <= 1'b1;
                    end
                    row_q <= row_d;
                    // Row check uses the count including a same-cycle valid.
                    if (mm_done) begin
                        state_q <= ST_NEXT;
                        if (row_d != ROWS) begin
                            err_q <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_NEXT: begin
                    if (col_q == LAST_COL) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        col_q      <= col_q + CW'(1);
                        row_q      <= '0;
                        state_q    <= ST_LAUNCH;
                        mm_start_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sched_busy        = busy_q;
    assign sched_done        = done_q;
    assign sched_error       = err_q;
    assign mm_start          = mm_start_q;
    assign mm_col            = col_q;
    assign res_write_en      = wr_en_q;
    assign res_write_address = wr_addr_q;
    assign res_write_data    = wr_data_q;

endmodule

// File: tb/tb_mmult_sched.sv
// tb/tb_mmult_sched.sv - scoreboard bench for mmult_sched (M=4, P=2)
module tb_mmult_sched;

    localparam int WIDTH = 8;
    localparam int M     = 4;
    localparam int P     = 2;
    localparam int AW    = 4;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             aresetn = 1'b1;
    logic             sched_start = 1'b0;
    logic             mm_done = 1'b0;
    logic             mm_result_valid = 1'b0;
    logic [WIDTH-1:0] mm_result = '0;
    logic             sched_busy, sched_done, sched_error, mm_start;
    logic [0:0]       mm_col;
    logic             res_write_en;
    logic [AW-1:0]    res_write_address;
    logic [WIDTH-1:0] res_write_data;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    logic [AW+WIDTH-1:0] exp_q[$];

    mmult_sched #(
        .WIDTH          (WIDTH),
        .M              (M),
        .P              (P),
        .RES_DEPTH_BITS (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .sched_start       (sched_start),
        .sched_busy        (sched_busy),
        .sched_done        (sched_done),
        .sched_error       (sched_error),
        .mm_start          (mm_start),
        .mm_col            (mm_col),
        .mm_done           (mm_done),
        .mm_result_valid   (mm_result_valid),
        .mm_result         (mm_result),
        .res_write_en      (res_write_en),
        .res_write_address (res_write_address),
        .res_write_data    (res_write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: counts pulses and pops the scoreboard on every RAM write.
    always @(negedge clk) begin
        logic [AW+WIDTH-1:0] e;
        if (mm_start) start_cnt++;
        if (sched_done) done_cnt++;
        if (res_write_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr %0d data %0d with empty queue",
                         res_write_address, res_write_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", res_write_address, e[AW+WIDTH-1:WIDTH]);
                chk("wr_data", res_write_data, e[WIDTH-1:0]);
            end
        end
    end

    // Entered at the negedge of the LAUNCH cycle; returns at the negedge after mm_done sampling.
    task automatic drive_col(input int c, input int base, input int nvalid,
                             input bit coincide, input bit poke);
        @(negedge clk);
        chk("mm_col", mm_col, c);
        for (int r = 0; r < nvalid; r++) begin
            mm_result_valid = 1'b1;
            mm_result       = WIDTH'(base + r);
            if (r < M) exp_q.push_back({AW'(c * M + r), WIDTH'(base + r)});
            sched_start = poke && (r == 1);
            mm_done     = coincide && (r == nvalid - 1);
            @(negedge clk);
        end
        mm_result_valid = 1'b0;
        sched_start     = 1'b0;
        if (!coincide) begin
            mm_done = 1'b1;
            @(negedge clk);
        end
        mm_done = 1'b0;
    endtask

    task automatic run_two(input int b0, input int n0, input bit co0,
                           input int b1, input int n1, input bit co1,
                           input bit poke, input bit exp_err);
        int s0, d0;
        s0 = start_cnt;
        d0 = done_cnt;
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
        chk("start_to_mm_start", mm_start, 1);
        chk("busy_after_start", sched_busy, 1);
        chk("error_cleared", sched_error, 0);
        drive_col(0, b0, n0, co0, poke);
        chk("gap_no_start", mm_start, 0);
        @(negedge clk);
        chk("next_mm_start", mm_start, 1);
        drive_col(1, b1, n1, co1, 1'b0);
        chk("done_not_early", sched_done, 0);
        chk("busy_in_next", sched_busy, 1);
        @(negedge clk);
        chk("sched_done", sched_done, 1);
        chk("busy_drop", sched_busy, 0);
        chk("sched_error", sched_error, exp_err);
        @(negedge clk);
        chk("done_one_cycle", sched_done, 0);
        chk("mm_start_count", start_cnt - s0, 2);
        chk("done_count", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, sched_busy, 0);
        chk({tag, "_done"}, sched_done, 0);
        chk({tag, "_error"}, sched_error, 0);
        chk({tag, "_mm_start"}, mm_start, 0);
        chk({tag, "_mm_col"}, mm_col, 0);
        chk({tag, "_wr_en"}, res_write_en, 0);
        chk({tag, "_wr_addr"}, res_write_address, 0);
        chk({tag, "_wr_data"}, res_write_data, 0);
    endtask

    initial begin
        #2 aresetn = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        aresetn = 1'b1;
        @(negedge clk);

        // Normal run, results 10..13 then 20..23 at addresses 0..7.
        run_two(10, 4, 1'b0, 20, 4, 1'b0, 1'b0, 1'b0);
        // Extra start pulse mid-column 0 is ignored.
        run_two(40, 4, 1'b0, 50, 4, 1'b0, 1'b1, 1'b0);
        // Short column 0 (3 valids): column 1 still runs, error set.
        run_two(60, 3, 1'b0, 70, 4, 1'b0, 1'b0, 1'b1);
        // Last valid coincides with mm_done; also clears previous error.
        run_two(80, 4, 1'b1, 90, 4, 1'b1, 1'b0, 1'b0);
        // Overflow: fifth valid in column 0 dropped, error set.
        run_two(130, 5, 1'b0, 140, 4, 1'b0, 1'b0, 1'b1);

        // Reset during WAIT of column 1.
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
        drive_col(0, 100, 4, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_mm_col", mm_col, 1);
        for (int r = 0; r < 2; r++) begin
            mm_result_valid = 1'b1;
            mm_result       = WIDTH'(110 + r);
            exp_q.push_back({AW'(M + r), WIDTH'(110 + r)});
            @(negedge clk);
        end
        mm_result_valid = 1'b0;
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        run_two(150, 4, 1'b0, 160, 4, 1'b0, 1'b0, 1'b0);

`ifdef MMULT_SCHED_TIMEOUT_EN
        begin
            int early;
            early = 0;
            sched_start = 1'b1;
            @(negedge clk);
            sched_start = 1'b0;
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                mm_result_valid = 1'b1;
                mm_result       = WIDTH'(200 + r);
                exp_q.push_back({AW'(r), WIDTH'(200 + r)});
                if (r == 1) begin
                    @(negedge clk);
                    mm_result_valid = 1'b0;
                end else begin
                    @(negedge clk);
                end
            end
            // Now one cycle past the last valid; done due 17 cycles after it.
            if (sched_done) early++;
            for (int k = 2; k <= 17; k++) begin
                @(negedge clk);
                if (k < 17 && sched_done) early++;
            end
            chk("timeout_no_early_done", early, 0);
            chk("timeout_done", sched_done, 1);
            chk("timeout_error", sched_error, 1);
            chk("timeout_busy", sched_busy, 0);
            @(negedge clk);
            chk("timeout_done_one_cycle", sched_done, 0);
            run_two(210, 4, 1'b0, 220, 4, 1'b0, 1'b0, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation reached %0t without finishing", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
